// File: rtl/csa_pkg.sv
// ============================================================================
//  Module   : csa_pkg
//  Brief    : Shared state encoding and width helper for the CSA accumulator.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package csa_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_t;

  // Enough headroom for lanes*max_beats operands of the given width.
  function automatic int acc_width(input int width, input int lanes, input int max_beats);
    return width + $clog2(lanes * max_beats);
  endfunction

endpackage

`default_nettype wire

// File: rtl/csa_row.sv
// ============================================================================
//  Module   : csa_row
//  Brief    : One 3:2 carry-save compressor row; c carries weight 2.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module csa_row #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);

endmodule

`default_nettype wire

// File: rtl/csa_stream_accumulator.sv
// ============================================================================
//  Module   : csa_stream_accumulator
//  Brief    : Streaming multi-lane carry-save accumulator with one-cycle resolve.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module csa_stream_accumulator
  import csa_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LANES     = 3,
  parameter int MAX_BEATS = 16,
  localparam int ACC_W    = acc_width(WIDTH, LANES, MAX_BEATS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_sum,
  output logic                   out_overflow
);

  localparam int CNT_W = $clog2(MAX_BEATS + 2);
  localparam logic [CNT_W-1:0] c_cnt_sat = CNT_W'(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(MAX_BEATS);

  state_t           r_state;
  state_t           w_next;
  logic [ACC_W-1:0] r_sum;
  logic [ACC_W-1:0] r_carry;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             w_accept;
  logic             w_out_fire;

  logic [ACC_W-1:0] w_lane [LANES];
  logic [ACC_W-1:0] w_x    [LANES];
  logic [ACC_W-1:0] w_y    [LANES];
  logic [ACC_W-1:0] w_s    [LANES];
  logic [ACC_W-1:0] w_c    [LANES];

  // Row 0 folds the stored pair with lane 0; each later row folds in one more lane.
  for (genvar i = 0; i < LANES; i++) begin : g_row
    assign w_lane[i] = ACC_W'(in_data[i*WIDTH +: WIDTH]);
    if (i == 0) begin : g_first
      assign w_x[i] = r_sum;
      assign w_y[i] = r_carry << 1;
    end else begin : g_chain
      assign w_x[i] = w_s[i-1];
      assign w_y[i] = w_c[i-1] << 1;
    end
    csa_row #(.W(ACC_W)) u_row (
      .x (w_x[i]),
      .y (w_y[i]),
      .z (w_lane[i]),
      .s (w_s[i]),
      .c (w_c[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_ACCUM;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) w_next = ST_RESOLVE;
      end
      ST_RESOLVE: w_next = ST_OUTPUT;
      ST_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_ACCUM;
      end
      default: w_next = ST_ACCUM;
    endcase
    if (clr) w_next = ST_ACCUM;
  end

  assign w_accept   = in_valid  & in_ready  & ~clr;
  assign w_out_fire = out_valid & out_ready & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum        <= '0;
      r_carry      <= '0;
      r_beat_cnt   <= '0;
      out_sum      <= '0;
      out_overflow <= 1'b0;
    end else begin
      if (clr || w_out_fire) begin
        r_sum      <= '0;
        r_carry    <= '0;
        r_beat_cnt <= '0;
      end else if (w_accept) begin
        r_sum   <= w_s[LANES-1];
        r_carry <= w_c[LANES-1];
        if (r_beat_cnt != c_cnt_sat) r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      // Single carry-propagate add, only in the resolve cycle.
      if (r_state == ST_RESOLVE && !clr) begin
        out_sum      <= r_sum + (r_carry << 1);
        out_overflow <= (r_beat_cnt > c_cnt_max);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_csa_stream_accumulator.sv
// ============================================================================
//  Module   : tb_csa_stream_accumulator
//  Brief    : Scoreboard bench for csa_stream_accumulator at default parameters.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_csa_stream_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_sum;
  logic        out_overflow;

  typedef struct packed {
    logic [9:0] sum;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_acc = 0;
  int   exp_cnt = 0;

  csa_stream_accumulator #(.WIDTH(4), .LANES(3), .MAX_BEATS(16)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !clr) begin
      if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("out_sum", 32'(out_sum), 32'(e.sum));
        chk("out_overflow", 32'(out_overflow), 32'(e.ovf));
      end
    end
  end

  task automatic send_beat(input int a, input int b, input int c, input bit last);
    int t = 0;
    in_valid = 1'b1;
    in_data  = {4'(c), 4'(b), 4'(a)};
    in_last  = last;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    exp_acc += a + b + c;
    exp_cnt++;
    if (last) begin
      sb_q.push_back('{sum: 10'(exp_acc), ovf: (exp_cnt > 16)});
      exp_acc = 0;
      exp_cnt = 0;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (!(out_valid && out_ready) && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!(out_valid && out_ready)) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;

    // Reset held with random inputs
    repeat (3) begin
      in_valid  = 1'($urandom);
      in_data   = 12'($urandom);
      in_last   = 1'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum", 32'(out_sum), 0);
    chk("rst_out_ovf", 32'(out_overflow), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single beat and latency
    send_beat(1, 2, 4, 1);
    chk("lat_resolve", 32'(out_valid), 0);
    @(posedge clk); #1;
    chk("lat_valid", 32'(out_valid), 1);
    @(posedge clk); #1;
    chk("valid_one_cycle", 32'(out_valid), 0);

    // Three beats with an idle gap
    send_beat(9, 5, 3, 0);
    @(posedge clk); #1;
    send_beat(15, 15, 1, 0);
    send_beat(10, 5, 14, 1);
    drain();

    // Capacity, overflow, and flag scoped to one packet
    for (int i = 0; i < 16; i++) send_beat(15, 15, 15, i == 15);
    drain();
    for (int i = 0; i < 17; i++) send_beat(15, 15, 15, i == 16);
    drain();
    send_beat(1, 1, 1, 1);
    drain();

    // Backpressure
    out_ready = 1'b0;
    send_beat(3, 3, 3, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 12'($urandom);
      in_last  = 1'b0;
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_hold", 32'(out_sum), 9);
      @(posedge clk); #1;
    end
    in_data = {4'd3, 4'd2, 4'd1}; in_last = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_ready", 32'(in_ready), 1);
    chk("post_hs_valid", 32'(out_valid), 0);
    sb_q.push_back('{sum: 10'd6, ovf: 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    drain();

    // clr mid-packet; the beat alongside clr must be dropped
    send_beat(15, 15, 15, 0);
    send_beat(15, 15, 15, 0);
    in_valid = 1'b1; in_data = 12'hFFF; in_last = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    exp_acc = 0; exp_cnt = 0;
    send_beat(1, 0, 0, 1);
    drain();

    // clr during OUTPUT discards the pending result
    out_ready = 1'b0;
    send_beat(2, 0, 0, 1);
    @(posedge clk); #1;
    chk("pre_clr_valid", 32'(out_valid), 1);
    void'(sb_q.pop_back());
    clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_drop_valid", 32'(out_valid), 0);
    chk("clr_in_ready", 32'(in_ready), 1);
    send_beat(5, 5, 5, 1);
    drain();

    // Asynchronous reset mid-packet
    send_beat(15, 15, 15, 0);
    send_beat(15, 15, 15, 0);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_acc = 0; exp_cnt = 0;
    send_beat(2, 2, 2, 1);
    drain();

    // Asynchronous reset mid-OUTPUT
    out_ready = 1'b0;
    send_beat(4, 4, 4, 1);
    @(posedge clk); #1;
    chk("pre_rst_valid", 32'(out_valid), 1);
    void'(sb_q.pop_back());
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(out_valid), 0);
    chk("rst_async_sum", 32'(out_sum), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    send_beat(1, 1, 0, 1);
    drain();

    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
